shared_bus_xfer: RTL and testbench

SHARED_BUS_XFER -- requirements
Module: shared_bus_xfer

---
 rtl/xfer_pkg.sv | 23 ++
 rtl/xfer_beat_counter.sv | 36 +++
 rtl/shared_bus_xfer.sv | 88 ++++++++
 tb/tb_shared_bus_xfer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xfer_pkg.sv
// Shared encodings for the shared-bus burst transfer block: FSM states and owner codes.
package xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER1 = 2'd1,
        ST_XFER2 = 2'd2,
        ST_DONE  = 2'd3
    } xfer_state_e;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_C1   = 2'd1;
    localparam logic [1:0] OWN_C2   = 2'd2;

    function automatic logic [1:0] owner_of(input xfer_state_e st);
        case (st)
            ST_XFER1: owner_of = OWN_C1;
            ST_XFER2: owner_of = OWN_C2;
            default:  owner_of = OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/xfer_beat_counter.sv
// Beat counter for one burst; 'last' flags the accepted beat that closes the burst.
module xfer_beat_counter
    import xfer_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    output logic last
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = inc && (cnt_q == LAST_CNT);

    // Wrap to zero on the closing beat so the next burst starts clean.
    always_comb begin
        cnt_d = cnt_q;
        if (last)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/shared_bus_xfer.sv
// Grants one of two clients a fixed-length burst onto a shared valid/ready bus.
// Optional even-parity output enabled by defining SHARED_BUS_XFER_PARITY_EN.
module shared_bus_xfer
    import xfer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              grant1,
    input  logic              grant2,
    input  logic [DATA_W-1:0] c1_data,
    input  logic [DATA_W-1:0] c2_data,
    input  logic              c1_valid,
    input  logic              c2_valid,
    output logic              c1_ready,
    output logic              c2_ready,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic [1:0]        owner,
    output logic              burst_done
`ifdef SHARED_BUS_XFER_PARITY_EN
   ,output logic              bus_parity
`endif
);

    xfer_state_e state_q, state_d;
    logic        inc, last;

    xfer_beat_counter #(.BURST_LEN(BURST_LEN)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (inc),
        .last    (last)
    );

    // Pass-through is purely combinational from the registered owner.
    always_comb begin
        state_d   = state_q;
        bus_valid = 1'b0;
        bus_data  = '0;
        c1_ready  = 1'b0;
        c2_ready  = 1'b0;
        inc       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant1)
                    state_d = ST_XFER1;
                else if (grant2)
                    state_d = ST_XFER2;
            end
            ST_XFER1: begin
                bus_valid = c1_valid;
                bus_data  = c1_data;
                c1_ready  = bus_ready;
                inc       = c1_valid && bus_ready;
                if (last)
                    state_d = ST_DONE;
            end
            ST_XFER2: begin
                bus_valid = c2_valid;
                bus_data  = c2_data;
                c2_ready  = bus_ready;
                inc       = c2_valid && bus_ready;
                if (last)
                    state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    assign owner      = owner_of(state_q);
    assign burst_done = (state_q == ST_DONE);

`ifdef SHARED_BUS_XFER_PARITY_EN
    assign bus_parity = bus_valid & (^bus_data);
`endif

endmodule

// File: tb/tb_shared_bus_xfer.sv
// Scoreboard bench for shared_bus_xfer: a 4-beat instance plus a 1-beat instance.
module tb_shared_bus_xfer;
    localparam int DW = 8;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic          grant1, grant2, c1_valid, c2_valid, bus_ready;
    logic [DW-1:0] c1_data, c2_data;
    logic          c1_ready, c2_ready, bus_valid, burst_done;
    logic [DW-1:0] bus_data;
    logic [1:0]    owner;

    logic          b_grant1, b_c1_valid, b_bus_ready;
    logic [DW-1:0] b_c1_data;
    logic          b_c1_ready, b_c2_ready, b_bus_valid, b_burst_done;
    logic [DW-1:0] b_bus_data;
    logic [1:0]    b_owner;
`ifdef SHARED_BUS_XFER_PARITY_EN
    logic          par_a, par_b;
`endif

    shared_bus_xfer #(.DATA_W(DW), .BURST_LEN(4)) dut (
        .clock(clock), .reset_n(reset_n), .grant1(grant1), .grant2(grant2),
        .c1_data(c1_data), .c2_data(c2_data), .c1_valid(c1_valid), .c2_valid(c2_valid),
        .c1_ready(c1_ready), .c2_ready(c2_ready), .bus_data(bus_data), .bus_valid(bus_valid),
        .bus_ready(bus_ready), .owner(owner), .burst_done(burst_done)
`ifdef SHARED_BUS_XFER_PARITY_EN
       ,.bus_parity(par_a)
`endif
    );

    shared_bus_xfer #(.DATA_W(DW), .BURST_LEN(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .grant1(b_grant1), .grant2(1'b0),
        .c1_data(b_c1_data), .c2_data('0), .c1_valid(b_c1_valid), .c2_valid(1'b0),
        .c1_ready(b_c1_ready), .c2_ready(b_c2_ready), .bus_data(b_bus_data), .bus_valid(b_bus_valid),
        .bus_ready(b_bus_ready), .owner(b_owner), .burst_done(b_burst_done)
`ifdef SHARED_BUS_XFER_PARITY_EN
       ,.bus_parity(par_b)
`endif
    );

    typedef struct packed {
        logic [1:0]    own;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted bus beat must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && bus_valid === 1'b1 && bus_ready === 1'b1) begin
            beat_t e;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat: got %0h expected none", bus_data);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(bus_data), 32'(e.data));
                check("beat_owner", 32'(owner), 32'(e.own));
`ifdef SHARED_BUS_XFER_PARITY_EN
                check("beat_parity", 32'(par_a), 32'(^e.data));
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic beat(input int c, input logic [DW-1:0] d);
        beat_t e;
        if (c == 1) begin
            c1_data = d; c1_valid = 1'b1; e.own = 2'd1;
        end else begin
            c2_data = d; c2_valid = 1'b1; e.own = 2'd2;
        end
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        grant1 = 0; grant2 = 0; c1_valid = 0; c2_valid = 0; bus_ready = 0;
        c1_data = '0; c2_data = '0;
        b_grant1 = 0; b_c1_valid = 0; b_bus_ready = 0; b_c1_data = '0;

        // Reset state
        smp();
        check("rst_owner", 32'(owner), 0);
        check("rst_done", 32'(burst_done), 0);
        check("rst_bus_valid", 32'(bus_valid), 0);
        check("rst_bus_data", 32'(bus_data), 0);
        check("rst_c1_ready", 32'(c1_ready), 0);
        check("rst_c2_ready", 32'(c2_ready), 0);
        check("rst_b_owner", 32'(b_owner), 0);
        cyc(); reset_n = 1'b1;

        // Basic client1 burst from a one-cycle grant
        cyc(); grant1 = 1; c1_valid = 1; bus_ready = 1; c1_data = 8'h10;
        smp(); check("t1_idle_owner", 32'(owner), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); grant1 = 0; beat(1, 8'(8'h10 + i));
            smp();
            check("t1_owner", 32'(owner), 1);
            check("t1_c1_ready", 32'(c1_ready), 1);
            check("t1_c2_ready", 32'(c2_ready), 0);
            check("t1_done_early", 32'(burst_done), 0);
        end
        cyc(); c1_valid = 0;
        smp();
        check("t1_done", 32'(burst_done), 1);
        check("t1_done_owner", 32'(owner), 0);
        check("t1_done_valid", 32'(bus_valid), 0);
        cyc(); smp();
        check("t1_after_done", 32'(burst_done), 0);
        check("t1_after_owner", 32'(owner), 0);

        // Simultaneous grants: client1 wins, client2 never readied
        cyc(); grant1 = 1; grant2 = 1; c1_valid = 1; c2_valid = 1; c2_data = 8'hAA;
        smp(); check("t2_idle_c2_ready", 32'(c2_ready), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); grant1 = 0; grant2 = 0; beat(1, 8'(8'h20 + i));
            smp();
            check("t2_owner", 32'(owner), 1);
            check("t2_c2_ready", 32'(c2_ready), 0);
        end
        cyc(); c1_valid = 0; c2_valid = 0;
        smp(); check("t2_done", 32'(burst_done), 1);
        check("t2_done_c2_ready", 32'(c2_ready), 0);
        cyc(); smp(); check("t2_after_done", 32'(burst_done), 0);

        // Client2 burst with a 3-cycle bus stall after beat 2
        cyc(); grant2 = 1; c2_valid = 1; c2_data = 8'h30;
        smp();
        cyc(); grant2 = 0; beat(2, 8'h30); smp(); check("t3_owner", 32'(owner), 2);
        cyc(); beat(2, 8'h31); smp();
        for (int i = 0; i < 3; i++) begin
            cyc(); bus_ready = 0;
            smp();
            check("t3_stall_c2_ready", 32'(c2_ready), 0);
            check("t3_stall_owner", 32'(owner), 2);
            check("t3_stall_valid", 32'(bus_valid), 1);
            check("t3_stall_done", 32'(burst_done), 0);
        end
        cyc(); bus_ready = 1; beat(2, 8'h32); smp(); check("t3_resume_done", 32'(burst_done), 0);
        cyc(); beat(2, 8'h33); smp(); check("t3_last_done", 32'(burst_done), 0);
        cyc(); c2_valid = 0; smp(); check("t3_done", 32'(burst_done), 1);
        cyc(); smp(); check("t3_after_done", 32'(burst_done), 0);

        // Grant2 dropped after beat 1, plus a client valid gap
        cyc(); grant2 = 1; c2_valid = 1;
        smp();
        cyc(); beat(2, 8'h40); smp(); check("t4_owner", 32'(owner), 2);
        cyc(); grant2 = 0; c2_valid = 0;
        smp();
        check("t4_gap_owner", 32'(owner), 2);
        check("t4_gap_valid", 32'(bus_valid), 0);
        check("t4_gap_done", 32'(burst_done), 0);
        for (int i = 1; i < 4; i++) begin
            cyc(); beat(2, 8'(8'h40 + i));
            smp();
            check("t4_owner_hold", 32'(owner), 2);
            check("t4_done_early", 32'(burst_done), 0);
        end
        cyc(); c2_valid = 0; smp(); check("t4_done", 32'(burst_done), 1);
        cyc(); smp(); check("t4_after_done", 32'(burst_done), 0);
        check("t4_after_owner", 32'(owner), 0);
        cyc(); smp(); check("t4_single_pulse", 32'(burst_done), 0);

        // Reset mid-burst, then a fresh burst counts from beat 0
        cyc(); grant1 = 1; c1_valid = 1;
        smp();
        cyc(); grant1 = 0; beat(1, 8'h50); smp();
        cyc(); beat(1, 8'h51); smp();
        cyc(); reset_n = 0; c1_valid = 0;
        smp();
        check("t5_rst_owner", 32'(owner), 0);
        check("t5_rst_valid", 32'(bus_valid), 0);
        check("t5_rst_done", 32'(burst_done), 0);
        check("t5_rst_data", 32'(bus_data), 0);
        check("t5_rst_c1_ready", 32'(c1_ready), 0);
        cyc(); reset_n = 1;
        smp(); check("t5_rel_owner", 32'(owner), 0);
        for (int i = 0; i < 2; i++) begin
            cyc(); smp(); check("t5_no_done", 32'(burst_done), 0);
        end
        cyc(); grant1 = 1; c1_valid = 1;
        smp();
        for (int i = 0; i < 4; i++) begin
            cyc(); grant1 = 0; beat(1, 8'(8'h60 + i));
            smp();
            check("t5_owner", 32'(owner), 1);
            check("t5_done_early", 32'(burst_done), 0);
        end
        cyc(); c1_valid = 0; smp(); check("t5_done", 32'(burst_done), 1);
        cyc(); smp(); check("t5_after_done", 32'(burst_done), 0);

        // Single-beat burst on the BURST_LEN=1 instance
        cyc(); b_grant1 = 1; b_c1_valid = 1; b_bus_ready = 1; b_c1_data = 8'h07;
        smp(); check("t6_idle_owner", 32'(b_owner), 0);
`ifdef SHARED_BUS_XFER_PARITY_EN
        check("t6_idle_parity", 32'(par_b), 0);
`endif
        cyc(); b_grant1 = 0;
        smp();
        check("t6_owner", 32'(b_owner), 1);
        check("t6_data", 32'(b_bus_data), 32'h07);
        check("t6_valid", 32'(b_bus_valid), 1);
        check("t6_c1_ready", 32'(b_c1_ready), 1);
        check("t6_done_early", 32'(b_burst_done), 0);
`ifdef SHARED_BUS_XFER_PARITY_EN
        check("t6_parity", 32'(par_b), 1);
`endif
        cyc(); b_c1_valid = 0;
        smp();
        check("t6_done", 32'(b_burst_done), 1);
        check("t6_done_owner", 32'(b_owner), 0);
        cyc(); smp(); check("t6_after_done", 32'(b_burst_done), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
